raycast_stack_ctrl: RTL and testbench

- Sequencer and bounds guard in front of the memory-based traversal stack (push/pop strobes, combinational top-of-stack output, wrapping pointer, no occupancy tracking).
- Accepts one stack command at a time from the ray traversal FSM: push, pop, pop-to-level (octree ascend) and clear.
- Issues single-cycle push/pop strobes, tracks occupancy, flags overflow/underflow and returns popped frames over a valid/ready response channel.

---
 rtl/raycast_stack_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_raycast_stack_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/raycast_stack_ctrl.sv
// raycast_stack_ctrl
//   Sequencer and bounds guard placed in front of the memory-based ray
//   traversal stack. It takes one command at a time from the traversal
//   FSM: push, pop, pop-to-level (octree ascend) or clear. It issues
//   single-cycle push/pop strobes to the stack and keeps its own
//   occupancy count. That count is authoritative because the stack itself
//   only has a wrapping pointer. Each command is answered exactly once on
//   a valid/ready response channel.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   command handshake (ready only while idle)
//   req_op            00 push, 01 pop, 10 pop-to-level, 11 clear
//   req_data          frame to push
//   req_level         target occupancy for pop-to-level
//   rsp_valid/ready   response handshake, held until consumed
//   rsp_data          last popped frame, pushed frame echo, or 0
//   rsp_err           overflow / underflow / unreachable target
//   stk_push/pop      registered one-cycle strobes to the stack
//   stk_wdata         frame presented to the stack on push
//   stk_rdata         current top-of-stack from the stack
//   level/empty/full  registered occupancy status
//
// Optional feature (macro RAYCAST_STACK_CTRL_STATS_EN)
//   max_level         high-water mark of level, cleared by clear and reset
//   err_count         saturating count of error responses, reset-only clear

module raycast_stack_ctrl #(
  parameter int dw         = 32,
  parameter int depth      = 8,
  parameter int depth_log2 = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [dw-1:0]         req_data,
  input  logic [depth_log2:0]   req_level,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [dw-1:0]         rsp_data,
  output logic                  rsp_err,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic [dw-1:0]         stk_wdata,
  input  logic [dw-1:0]         stk_rdata,
  output logic [depth_log2:0]   level,
  output logic                  empty,
  output logic                  full
`ifdef RAYCAST_STACK_CTRL_STATS_EN
  ,
  output logic [depth_log2:0]   max_level,
  output logic [15:0]           err_count
`endif
);

  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_POPTO = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [depth_log2:0] DEPTH_LV = depth[depth_log2:0];

  typedef enum logic [1:0] {
    IDLE,
    PUSH,
    POPN,
    RESP
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [depth_log2:0]   pops_left;
  logic [depth_log2:0]   pops_left_next;
  logic [depth_log2:0]   level_next;
  logic                  rsp_valid_next;
  logic [dw-1:0]         rsp_data_next;
  logic                  rsp_err_next;
  logic                  stk_push_next;
  logic                  stk_pop_next;
  logic [dw-1:0]         stk_wdata_next;
  logic                  clear_accept;
  logic                  accept;

  // Gated by rst_n so the command port reads not-ready while reset is held.
  assign req_ready = rst_n & (state == IDLE);
  assign accept    = req_valid & req_ready;

  // State register and all registered outputs. Asserting reset mid-pop
  // drops the strobes at once and discards the pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pops_left <= '0;
      level     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      stk_push  <= 1'b0;
      stk_pop   <= 1'b0;
      stk_wdata <= '0;
    end else begin
      state     <= state_next;
      pops_left <= pops_left_next;
      level     <= level_next;
      empty     <= (level_next == '0);
      full      <= (level_next == DEPTH_LV);
      rsp_valid <= rsp_valid_next;
      rsp_data  <= rsp_data_next;
      rsp_err   <= rsp_err_next;
      stk_push  <= stk_push_next;
      stk_pop   <= stk_pop_next;
      stk_wdata <= stk_wdata_next;
    end
  end

  // Next-state and next-output logic. Strobes default low, so each strobe
  // lasts one cycle unless POPN explicitly re-arms it for the next entry.
  always_comb begin
    state_next     = state;
    pops_left_next = pops_left;
    level_next     = level;
    rsp_valid_next = rsp_valid;
    rsp_data_next  = rsp_data;
    rsp_err_next   = rsp_err;
    stk_push_next  = 1'b0;
    stk_pop_next   = 1'b0;
    stk_wdata_next = stk_wdata;
    clear_accept   = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          case (req_op)
            OP_PUSH: begin
              if (full) begin
                state_next     = RESP;
                rsp_valid_next = 1'b1;
                rsp_err_next   = 1'b1;
                rsp_data_next  = '0;
              end else begin
                state_next     = PUSH;
                stk_push_next  = 1'b1;
                stk_wdata_next = req_data;
              end
            end
            OP_POP: begin
              if (empty) begin
                state_next     = RESP;
                rsp_valid_next = 1'b1;
                rsp_err_next   = 1'b1;
                rsp_data_next  = '0;
              end else begin
                state_next     = POPN;
                stk_pop_next   = 1'b1;
                pops_left_next = {{depth_log2{1'b0}}, 1'b1};
              end
            end
            OP_POPTO: begin
              if (req_level > level) begin
                state_next     = RESP;
                rsp_valid_next = 1'b1;
                rsp_err_next   = 1'b1;
                rsp_data_next  = '0;
              end else if (req_level == level) begin
                state_next     = RESP;
                rsp_valid_next = 1'b1;
                rsp_err_next   = 1'b0;
                rsp_data_next  = '0;
              end else begin
                state_next     = POPN;
                stk_pop_next   = 1'b1;
                pops_left_next = level - req_level;
              end
            end
            default: begin
              clear_accept   = 1'b1;
              level_next     = '0;
              state_next     = RESP;
              rsp_valid_next = 1'b1;
              rsp_err_next   = 1'b0;
              rsp_data_next  = '0;
            end
          endcase
        end
      end

      PUSH: begin
        level_next     = level + 1'b1;
        state_next     = RESP;
        rsp_valid_next = 1'b1;
        rsp_err_next   = 1'b0;
        rsp_data_next  = stk_wdata;
      end

      // stk_rdata is the live top entry, so the frame under the final pop
      // strobe is captured straight into the response register.
      POPN: begin
        level_next = level - 1'b1;
        if (pops_left == {{depth_log2{1'b0}}, 1'b1}) begin
          state_next     = RESP;
          pops_left_next = '0;
          rsp_valid_next = 1'b1;
          rsp_err_next   = 1'b0;
          rsp_data_next  = stk_rdata;
        end else begin
          stk_pop_next   = 1'b1;
          pops_left_next = pops_left - 1'b1;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_next     = IDLE;
          rsp_valid_next = 1'b0;
          rsp_err_next   = 1'b0;
          rsp_data_next  = '0;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef RAYCAST_STACK_CTRL_STATS_EN
  // High-water mark follows the next level so it moves in step with level.
  // An error response is counted once, when it is first raised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_level <= '0;
      err_count <= '0;
    end else begin
      if (clear_accept) begin
        max_level <= '0;
      end else if (level_next > max_level) begin
        max_level <= level_next;
      end
      if (rsp_err_next && !rsp_err && (err_count != 16'hFFFF)) begin
        err_count <= err_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_raycast_stack_ctrl.sv
// tb_raycast_stack_ctrl
//   Directed bench for raycast_stack_ctrl. A small wrapping memory stack
//   model sits behind the strobes. Each command is checked against
//   hand-computed response data, error flag, latency, strobe counts and
//   resulting level.

module tb_raycast_stack_ctrl;

  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_POPTO = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_data = '0;
  logic [3:0]  req_level = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        stk_push;
  logic        stk_pop;
  logic [31:0] stk_wdata;
  logic [31:0] stk_rdata;
  logic [3:0]  level;
  logic        empty;
  logic        full;
`ifdef RAYCAST_STACK_CTRL_STATS_EN
  logic [3:0]  max_level;
  logic [15:0] err_count;
`endif

  int passCount = 0;
  int checkCount = 0;
  int pushCycles = 0;
  int popCycles = 0;
  int popRuns = 0;
  int bothCycles = 0;
  logic prevPop = 1'b0;

  raycast_stack_ctrl #(.dw(32), .depth(8), .depth_log2(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .req_level (req_level),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .stk_push  (stk_push),
    .stk_pop   (stk_pop),
    .stk_wdata (stk_wdata),
    .stk_rdata (stk_rdata),
    .level     (level),
    .empty     (empty),
    .full      (full)
`ifdef RAYCAST_STACK_CTRL_STATS_EN
    ,
    .max_level (max_level),
    .err_count (err_count)
`endif
  );

  always #5 clk = ~clk;

  // Memory stack model: wrapping pointer, combinational top entry.
  logic [31:0] mem [0:7];
  logic [2:0]  sp = 3'd0;
  logic [2:0]  topIdx;
  assign topIdx    = sp - 3'd1;
  assign stk_rdata = mem[topIdx];

  always @(posedge clk) begin
    if (stk_push) begin
      mem[sp] <= stk_wdata;
      sp      <= sp + 3'd1;
    end else if (stk_pop) begin
      sp <= sp - 3'd1;
    end
  end

  // Strobe monitor sampled mid-cycle.
  always @(negedge clk) begin
    if (stk_push) pushCycles++;
    if (stk_pop) popCycles++;
    if (stk_pop && !prevPop) popRuns++;
    if (stk_push && stk_pop) bothCycles++;
    prevPop = stk_pop;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  // Drives one command, returns #1 after its accept edge.
  task automatic applyStimulus(input string tag, input logic [1:0] op,
                               input logic [31:0] data, input logic [3:0] lvl);
    @(negedge clk);
    checkOutput({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_data  = data;
    req_level = lvl;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Waits (bounded) for rsp_valid; lat 1 means visible right after accept.
  task automatic waitResponse(input string tag, output logic [31:0] data,
                              output logic err, output int lat);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!rsp_valid) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    data = rsp_data;
    err  = rsp_err;
  endtask

  task automatic runCmd(input string tag, input logic [1:0] op, input logic [31:0] data,
                        input logic [3:0] lvl, input logic [31:0] expData, input logic expErr,
                        input int expLat, input int expPush, input int expPop,
                        input logic [3:0] expLevel, input bit chkData);
    logic [31:0] gotData;
    logic        gotErr;
    int          lat;
    int          push0;
    int          pop0;
    push0 = pushCycles;
    pop0  = popCycles;
    applyStimulus(tag, op, data, lvl);
    waitResponse(tag, gotData, gotErr, lat);
    @(posedge clk);
    #1;
    checkOutput({tag, "_lat"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_err"}, {31'd0, gotErr}, {31'd0, expErr});
    if (chkData) checkOutput({tag, "_data"}, gotData, expData);
    checkOutput({tag, "_push"}, 32'(pushCycles - push0), 32'(expPush));
    checkOutput({tag, "_pop"}, 32'(popCycles - pop0), 32'(expPop));
    checkOutput({tag, "_level"}, {28'd0, level}, {28'd0, expLevel});
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    int          lat;
    int          runs0;
    bit          stable;
    int          spur;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd0);
    checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst_level", {28'd0, level}, 32'd0);
    checkOutput("rst_empty", {31'd0, empty}, 32'd1);
    checkOutput("rst_strobes", {30'd0, stk_push, stk_pop}, 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("first_idle_ready", {31'd0, req_ready}, 32'd1);

    // Three pushes, then two pops
    runCmd("push_a1", OP_PUSH, 32'hA1, 4'd0, 32'hA1, 1'b0, 2, 1, 0, 4'd1, 1'b1);
    runCmd("push_a2", OP_PUSH, 32'hA2, 4'd0, 32'hA2, 1'b0, 2, 1, 0, 4'd2, 1'b1);
    runCmd("push_a3", OP_PUSH, 32'hA3, 4'd0, 32'hA3, 1'b0, 2, 1, 0, 4'd3, 1'b1);
    runCmd("pop_a3", OP_POP, 32'h0, 4'd0, 32'hA3, 1'b0, 2, 0, 1, 4'd2, 1'b1);
    runCmd("pop_a2", OP_POP, 32'h0, 4'd0, 32'hA2, 1'b0, 2, 0, 1, 4'd1, 1'b1);
    runCmd("pop_a1", OP_POP, 32'h0, 4'd0, 32'hA1, 1'b0, 2, 0, 1, 4'd0, 1'b1);
    checkOutput("empty_after_pops", {31'd0, empty}, 32'd1);

    // Fill to capacity, reject overflow, drain in LIFO order
    for (int i = 0; i < 8; i++)
      runCmd($sformatf("fill%0d", i), OP_PUSH, 32'h10 + 32'(i), 4'd0, 32'h10 + 32'(i),
             1'b0, 2, 1, 0, 4'(i + 1), 1'b1);
    checkOutput("full_at_8", {31'd0, full}, 32'd1);
    runCmd("overflow", OP_PUSH, 32'hDEAD, 4'd0, 32'h0, 1'b1, 1, 0, 0, 4'd8, 1'b0);
    checkOutput("full_after_ovf", {31'd0, full}, 32'd1);
    for (int i = 0; i < 8; i++)
      runCmd($sformatf("drain%0d", i), OP_POP, 32'h0, 4'd0, 32'h17 - 32'(i),
             1'b0, 2, 0, 1, 4'(7 - i), 1'b1);

    // Pop-to-level from 5 down to 2
    for (int i = 1; i <= 5; i++)
      runCmd($sformatf("frame%0d", i), OP_PUSH, 32'(i), 4'd0, 32'(i),
             1'b0, 2, 1, 0, 4'(i), 1'b1);
    runs0 = popRuns;
    runCmd("popto2", OP_POPTO, 32'h0, 4'd2, 32'h3, 1'b0, 4, 0, 3, 4'd2, 1'b1);
    checkOutput("popto2_runs", 32'(popRuns - runs0), 32'd1);
    runCmd("popto_same", OP_POPTO, 32'h0, 4'd2, 32'h0, 1'b0, 1, 0, 0, 4'd2, 1'b1);
    runCmd("popto_above", OP_POPTO, 32'h0, 4'd4, 32'h0, 1'b1, 1, 0, 0, 4'd2, 1'b1);

    // Response held under back-pressure
    rsp_ready = 1'b0;
    applyStimulus("hold_pop", OP_POP, 32'h0, 4'd0);
    waitResponse("hold_pop", d, e, lat);
    checkOutput("hold_data", d, 32'h2);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h2 || req_ready !== 1'b0) stable = 1'b0;
    end
    checkOutput("hold_stable", {31'd0, stable}, 32'd1);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("hold_release_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("hold_release_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("hold_level", {28'd0, level}, 32'd1);

    // Clear, then underflow
    runCmd("clear", OP_CLEAR, 32'h0, 4'd0, 32'h0, 1'b0, 1, 0, 0, 4'd0, 1'b1);
    runCmd("underflow", OP_POP, 32'h0, 4'd0, 32'h0, 1'b1, 1, 0, 0, 4'd0, 1'b1);
`ifdef RAYCAST_STACK_CTRL_STATS_EN
    checkOutput("err_count", {16'd0, err_count}, 32'd3);
`endif

    // Reset in the middle of pop-to-level 6 -> 0
    for (int i = 0; i < 6; i++)
      runCmd($sformatf("deep%0d", i), OP_PUSH, 32'h21 + 32'(i), 4'd0, 32'h21 + 32'(i),
             1'b0, 2, 1, 0, 4'(i + 1), 1'b1);
`ifdef RAYCAST_STACK_CTRL_STATS_EN
    checkOutput("max_level_pre", {28'd0, max_level}, 32'd6);
`endif
    applyStimulus("popto0", OP_POPTO, 32'h0, 4'd0);
    @(posedge clk);
    #1;
    checkOutput("mid_pop_active", {31'd0, stk_pop}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_pop_drop", {30'd0, stk_push, stk_pop}, 32'd0);
    checkOutput("rst_mid_level", {28'd0, level}, 32'd0);
    checkOutput("rst_mid_rsp", {31'd0, rsp_valid}, 32'd0);
`ifdef RAYCAST_STACK_CTRL_STATS_EN
    checkOutput("max_level_post", {28'd0, max_level}, 32'd0);
    checkOutput("err_count_post", {16'd0, err_count}, 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    spur = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid || stk_pop || stk_push) spur++;
    end
    checkOutput("post_rst_quiet", 32'(spur), 32'd0);
    checkOutput("post_rst_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("never_both_strobes", 32'(bothCycles), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
